// File: rtl/serializador_if.sv
// Word handshake and serial output bundle between a word producer and the
// serializador transmit block.
interface serializador_if #(
    parameter int N = 4
);
    logic [N-1:0] in_par;
    logic         load;
    logic         ready;
    logic         bit_en;
    logic         out_serie;
    logic         out_valid;
    logic         done;
    logic         busy;

    modport master (
        output in_par, load, bit_en,
        input  ready, out_serie, out_valid, done, busy
    );

    modport slave (
        input  in_par, load, bit_en,
        output ready, out_serie, out_valid, done, busy
    );
endinterface

// File: rtl/serializador.sv
// Parallel-to-serial transmitter: one-word holding buffer feeding a shift
// register that emits one bit per bit_en strobe, words back-to-back.
module serializador #(
    parameter int N         = 4,
    parameter int logN      = 2,
    parameter int LSB_FIRST = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    serializador_if.slave  bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [logN-1:0] LAST = logN'(N - 1);

    state_t          state, state_next;
    logic [N-1:0]    hold_reg;
    logic            hold_full, hold_full_next;
    logic [N-1:0]    shift_reg, shift_next;
    logic [logN-1:0] cnt, cnt_next;
    logic            done_q, done_next;
    logic            accept;

    function automatic logic [N-1:0] step(input logic [N-1:0] v);
        return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
    endfunction

    assign accept        = bus.load & ~hold_full;
    assign bus.ready     = ~hold_full;
    assign bus.out_valid = (state == SHIFT);
    assign bus.busy      = (state == SHIFT) | hold_full;
    assign bus.done      = done_q;
    // shift_reg is cleared on leaving SHIFT, the gate keeps idle at 0 regardless
    assign bus.out_serie = (state == SHIFT) &
                           ((LSB_FIRST != 0) ? shift_reg[0] : shift_reg[N-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_full <= 1'b0;
            shift_reg <= '0;
            cnt       <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_next;
            hold_full <= hold_full_next;
            shift_reg <= shift_next;
            cnt       <= cnt_next;
            done_q    <= done_next;
        end
    end

    // Buffered word is data only; validity lives in hold_full.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_reg <= bus.in_par;
        end
    end

    always_comb begin
        state_next     = state;
        hold_full_next = hold_full;
        shift_next     = shift_reg;
        cnt_next       = cnt;
        done_next      = 1'b0;

        unique case (state)
            IDLE: begin
                if (hold_full) begin
                    shift_next     = hold_reg;
                    cnt_next       = '0;
                    hold_full_next = 1'b0;
                    state_next     = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.bit_en) begin
                    if (cnt != LAST) begin
                        shift_next = step(shift_reg);
                        cnt_next   = cnt + logN'(1);
                    end else begin
                        done_next = 1'b1;
                        if (hold_full) begin
                            shift_next     = hold_reg;
                            cnt_next       = '0;
                            hold_full_next = 1'b0;
                        end else begin
                            shift_next = '0;
                            cnt_next   = '0;
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Accept only happens with the buffer empty, so it never races a drain.
        if (accept) begin
            hold_full_next = 1'b1;
        end
    end
endmodule

// File: tb/tb_serializador.sv
// Scoreboard bench: MSB-first and LSB-first transmitters driven in lockstep,
// checked against a word-queue reference model.
module tb_serializador;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] in_par = '0;
    logic         load   = 1'b0;
    logic         bit_en = 1'b0;

    serializador_if #(.N(N)) bus_m ();
    serializador_if #(.N(N)) bus_l ();

    assign bus_m.in_par = in_par;
    assign bus_m.load   = load;
    assign bus_m.bit_en = bit_en;
    assign bus_l.in_par = in_par;
    assign bus_l.load   = load;
    assign bus_l.bit_en = bit_en;

    serializador #(.N(N), .logN(2), .LSB_FIRST(0)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));
    serializador #(.N(N), .logN(2), .LSB_FIRST(1)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));

    int n_vec = 0;
    int n_err = 0;

    bit exp_m[$];
    bit exp_l[$];

    // Reference model: buffer occupancy and bits remaining in the current word.
    bit m_full = 1'b0;
    int m_left = 0;
    bit m_done = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = (m_left > 0);
        check("m.out_valid", bus_m.out_valid, v);
        check("l.out_valid", bus_l.out_valid, v);
        check("m.done", bus_m.done, m_done);
        check("l.done", bus_l.done, m_done);
        check("m.ready", bus_m.ready, !m_full);
        check("l.ready", bus_l.ready, !m_full);
        check("m.busy", bus_m.busy, v | m_full);
        if (!v) begin
            check("m.idle_serie", bus_m.out_serie, 1'b0);
            check("l.idle_serie", bus_l.out_serie, 1'b0);
        end
    endtask

    task automatic cycle(input bit ld, input logic [N-1:0] d, input bit be);
        bit acc;
        @(negedge clk);
        load   = ld;
        in_par = d;
        bit_en = be;
        @(posedge clk);
        acc    = ld && !m_full;
        m_done = 1'b0;
        if (m_left > 0) begin
            if (be) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    if (m_full) begin
                        m_left = N;
                        m_full = 1'b0;
                    end
                end
            end
        end else if (m_full) begin
            m_left = N;
            m_full = 1'b0;
        end
        if (acc) begin
            m_full = 1'b1;
            for (int i = N - 1; i >= 0; i--) exp_m.push_back(d[i]);
            for (int i = 0; i < N; i++) exp_l.push_back(d[i]);
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        load   = 1'b0;
        bit_en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        m_full = 1'b0;
        m_left = 0;
        m_done = 1'b0;
        exp_m.delete();
        exp_l.delete();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: each consumed bit is compared with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bit_en) begin
                if (bus_m.out_valid) begin
                    if (exp_m.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL m.unexpected_bit at %0t: got %b, expected none", $time, bus_m.out_serie);
                    end else begin
                        check("m.out_serie", bus_m.out_serie, exp_m.pop_front());
                    end
                end
                if (bus_l.out_valid) begin
                    if (exp_l.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL l.unexpected_bit at %0t: got %b, expected none", $time, bus_l.out_serie);
                    end else begin
                        check("l.out_serie", bus_l.out_serie, exp_l.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Single word, strobe every 3 clocks
        cycle(1'b1, 4'b1011, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 4'b0000, (i % 3) == 2);

        // Back-to-back, then overrun attempt while the buffer is full
        cycle(1'b1, 4'b1100, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b1, 4'b0110, 1'b0);
        cycle(1'b1, 4'b1111, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 4'b1111, (i % 2) == 1);

        // Idle strobes
        for (int i = 0; i < 8; i++) cycle(1'b0, 4'b0000, (i % 2) == 0);

        // Reset mid-word with a second word buffered
        cycle(1'b1, 4'b1010, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b1, 4'b0101, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'b0000, 1'b1);

        // bit_en held high, load coinciding with the last bit
        cycle(1'b1, 4'b1011, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b1, 4'b0011, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b0, 4'b0000, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cycle(($urandom % 3) == 0, 4'($urandom), ($urandom % 2) == 0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 4'b0000, 1'b1);

        n_vec++;
        if (exp_m.size() != 0 || exp_l.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d/%0d bits left, expected 0", exp_m.size(), exp_l.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
